// File: rtl/id_retire_tracker_if.sv
// Handshake bundle between the issue/writeback side and the in-order retire port
// of the instruction ID tracker.
interface id_retire_tracker_if #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = $clog2(DEPTH),
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic [ID_W-1:0]   issue_id;
    logic              wb_valid;
    logic [ID_W-1:0]   wb_id;
    logic [DATA_W-1:0] wb_data;
    logic              retire_valid;
    logic              retire_ready;
    logic [ID_W-1:0]   retire_id;
    logic [DATA_W-1:0] retire_data;
    logic              complete;
    logic [ID_W-1:0]   complete_id;
    logic              order_empty;
    logic              order_full;
    logic              proto_err;

    modport slave (
        input  issue_valid, issue_id, wb_valid, wb_id, wb_data, retire_ready,
        output retire_valid, retire_id, retire_data, complete, complete_id,
               order_empty, order_full, proto_err
    );

    modport master (
        output issue_valid, issue_id, wb_valid, wb_id, wb_data, retire_ready,
        input  retire_valid, retire_id, retire_data, complete, complete_id,
               order_empty, order_full, proto_err
    );
endinterface

// File: rtl/id_retire_tracker.sv
// Records issue order of instruction IDs, collects out-of-order writebacks and
// retires IDs strictly in issue order, handing each one back via complete.
module id_retire_tracker #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    id_retire_tracker_if.slave bus
);
    localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

    logic [ID_W-1:0]   fifo_q [DEPTH];
    logic [ID_W-1:0]   fifo_d [DEPTH];
    logic [ID_W-1:0]   head_q, head_d;
    logic [ID_W-1:0]   tail_q, tail_d;
    logic [ID_W:0]     count_q, count_d;
    logic [DEPTH-1:0]  pending_q, pending_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              proto_err_q, proto_err_d;

    logic [ID_W-1:0]   head_id;
    logic              retire_valid;
    logic              fire;
    logic              head_reissue;
    logic              issue_ok;
    logic              wb_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_id      = fifo_q[head_q];
        retire_valid = rst && (count_q != '0) && done_q[head_id];
        fire         = retire_valid && bus.retire_ready;
        head_reissue = fire && (bus.issue_id == head_id);

        // Full or already-pending IDs are only acceptable when the slot/ID frees up this cycle.
        issue_ok = bus.issue_valid && ((count_q != FULL_CNT) || fire)
                   && (!pending_q[bus.issue_id] || head_reissue);
        wb_ok    = bus.wb_valid && pending_q[bus.wb_id] && !done_q[bus.wb_id]
                   && !(issue_ok && (bus.issue_id == bus.wb_id));

        fifo_d    = fifo_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pending_d = pending_q;
        done_d    = done_q;
        count_d   = count_q;

        if (fire) begin
            head_d             = head_q + 1'b1;
            pending_d[head_id] = 1'b0;
            done_d[head_id]    = 1'b0;
        end
        if (wb_ok) begin
            done_d[bus.wb_id] = 1'b1;
            data_d[bus.wb_id] = bus.wb_data;
        end
        // Issue is applied last so a reissue of the retiring ID overrides the retire clear.
        if (issue_ok) begin
            fifo_d[tail_q]          = bus.issue_id;
            tail_d                  = tail_q + 1'b1;
            pending_d[bus.issue_id] = 1'b1;
            done_d[bus.issue_id]    = 1'b0;
        end

        case ({issue_ok, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        proto_err_d = proto_err_q
                      || (bus.issue_valid && !issue_ok)
                      || (bus.wb_valid && !wb_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_q      <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            done_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: result storage is not reset; done bits gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.retire_valid = retire_valid;
    assign bus.retire_id    = head_id;
    assign bus.retire_data  = retire_valid ? data_q[head_id] : '0;
    assign bus.complete     = fire;
    assign bus.complete_id  = head_id;
    assign bus.order_empty  = (count_q == '0);
    assign bus.order_full   = (count_q == FULL_CNT);
    assign bus.proto_err    = proto_err_q;

endmodule

// File: doc/id_retire_tracker.md
# id_retire_tracker

Consumer end of the instruction ID protocol. It records the order in which IDs are issued and collects writeback results, which may arrive out of order from the functional units. It then retires IDs strictly in issue order through a valid/ready port. Each retirement is returned to the ID generator as `complete`/`complete_id`, so that ID becomes free.

## Interface
Parameters:
- DEPTH, 4: number of instruction IDs; must equal INSTRUCTION_QUEUE_DEPTH, power of two ≥ 2
- ID_W, $clog2(DEPTH): ID width
- DATA_W, 32: writeback result width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (rst=0 resets on the next rising edge)
- issue_valid  in  1  an ID is issued this cycle (generator `advance`)
- issue_id  in  ID_W  ID being issued
- wb_valid  in  1  functional-unit result valid
- wb_id  in  ID_W  ID of the result
- wb_data  in  DATA_W  result value
- retire_valid  out  1  head ID completed and presentable
- retire_ready  in  1  downstream accepts retirement
- retire_id  out  ID_W  ID at head of order queue
- retire_data  out  DATA_W  result of head ID
- complete  out  1  retirement handshake occurred this cycle (to generator)
- complete_id  out  ID_W  ID retired this cycle
- order_empty  out  1  no outstanding IDs
- order_full  out  1  DEPTH IDs outstanding
- proto_err  out  1  sticky protocol-violation flag

## Operation
State:
- Order FIFO of DEPTH×ID_W entries.
- head and tail pointers, ID_W bits, wrap modulo DEPTH.
- count, ID_W+1 bits, range 0..DEPTH.
- Per-ID bits `pending` and `done`, plus per-ID result register data[DEPTH].

Issue (`issue_valid`):
- Accepted when count<DEPTH, or when count==DEPTH and a retirement fires the same cycle.
- On accept: write FIFO[tail]=issue_id, tail++, pending[issue_id]=1, done[issue_id]=0.
- Issue while full with no retirement, or of an ID already pending and not retiring this cycle: ignored, proto_err set.

Writeback (`wb_valid`):
- Accepted if pending[wb_id]=1 and done[wb_id]=0.
- On accept: done[wb_id]=1, data[wb_id]=wb_data.
- Writeback to a non-pending ID, or a duplicate to a done ID: ignored (data not overwritten), proto_err set.

Retire:
- retire_valid = rst & (count≠0) & done[FIFO[head]].
- retire_id = FIFO[head].
- retire_data = data[FIFO[head]] when retire_valid=1, else 0.
- Fire = retire_valid & retire_ready.
- On fire: head++, pending and done of retire_id cleared.
- complete = fire; complete_id = retire_id, combinational, same cycle.

Counter and flags:
- Issue only: count+1. Fire only: count−1. Both or neither: unchanged.
- order_empty = (count==0); order_full = (count==DEPTH).

Simultaneous events:
- Issue of the ID retiring this same cycle (generator reuses complete_id): legal. Issue's set of pending and clear of done win over the retire clear.
- Writeback to the head ID while that head is not yet done: done is set at the edge; no same-cycle bypass.
- Writeback and issue of the same ID in the same cycle: the issue is processed, the writeback is treated as non-pending, and proto_err is set.

proto_err is cleared only by reset.

Reset: count=0, head=tail=0, all pending/done=0, proto_err=0. Outputs after reset: retire_valid=0, complete=0, retire_data=0, order_empty=1, order_full=0. retire_id and complete_id are 0 after reset. data[] is not reset. Reset asserted mid-operation discards all outstanding IDs and results at that edge. While rst=0, retire_valid and complete are forced 0.

## Timing
- Writeback at cycle N to the head ID produces retire_valid=1 in cycle N+1.
- Issue at cycle N is earliest retirable in cycle N+2, via writeback in cycle N+1.
- Throughput: one issue, one writeback and one retirement per cycle, concurrently.
- complete is combinational from retire_valid and retire_ready. There is no combinational path from issue_* or wb_* to any output.
- Stalled retirement (retire_ready=0) holds retire_valid, retire_id and retire_data stable.

## Test plan
- Reset, then issue IDs 3,1 and write back 1 (0xAA) then 3 (0xBB), with retire_ready=1 → retirements in order 3 (0xBB) then 1 (0xAA); complete pulses with complete_id 3, then 1.
- Issue 0,1,2,3, so order_full=1. Write back 3,2,1,0 on consecutive cycles → nothing retires until 0 is done; then 0,1,2,3 retire on four consecutive cycles; order_empty=1 after.
- Full queue with head 0 done, retire_ready=1, same-cycle issue of ID 0 → count stays 4, ID 0 at tail with pending=1 and done=0, proto_err=0.
- Hold retire_ready=0 for 5 cycles with the head done (ID 2, 0x1234) → retire_valid, retire_id=2 and retire_data=0x1234 stable, complete=0; release → one fire.
- Writeback to non-pending ID 2, then a duplicate writeback to a done ID with new data → proto_err=1, stored data unchanged, retirement order unaffected.
- Three IDs outstanding, two done; assert rst=0 for one cycle → next cycle count=0, order_empty=1, retire_valid=0, proto_err=0; a fresh issue/writeback works normally.
